ram_responder: RTL

//  Memory-side responder for the core's fetch, load and store ports: word-addressed RAM, 1-cycle read latency, byte-enable writes.

---
 rtl/ram_responder_if.sv | 47 ++++
 rtl/ram_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ram_responder_if.sv
// Core/host-facing bundle for ram_responder: fetch, data read, data write,
// byte-stream loader and status.
//   master : core + host loader side (drives addresses, write data, loader bytes)
//   slave  : ram_responder side (returns read data, loader ready, status)
interface ram_responder_if #(
    parameter int unsigned ADDR_WIDTH = 31,
    parameter int unsigned DATA_WIDTH = 31,
    parameter int unsigned DEPTH_LOG2 = 12
);
    // fetch port
    logic [ADDR_WIDTH:0] read_fetch_addr;
    logic [DATA_WIDTH:0] read_fetch_data;
    // data read port
    logic                read_req;
    logic [ADDR_WIDTH:0] read_addr;
    logic [DATA_WIDTH:0] read_data;
    // data write port
    logic                write_enable;
    logic [3:0]          byte_enable;
    logic [ADDR_WIDTH:0] write_addr;
    logic [DATA_WIDTH:0] write_data;
    // program loader stream
    logic                load_valid;
    logic                load_ready;
    logic [7:0]          load_byte;
    logic                load_last;
    // status
    logic                core_rst;
    logic [DEPTH_LOG2:0] load_words;
    logic                fault;

    modport master (
        output read_fetch_addr, input read_fetch_data,
        output read_req, read_addr, input read_data,
        output write_enable, byte_enable, write_addr, write_data,
        output load_valid, load_byte, load_last, input load_ready,
        input core_rst, load_words, fault
    );

    modport slave (
        input read_fetch_addr, output read_fetch_data,
        input read_req, read_addr, output read_data,
        input write_enable, byte_enable, write_addr, write_data,
        input load_valid, load_byte, load_last, output load_ready,
        output core_rst, load_words, fault
    );
endinterface

// File: rtl/ram_responder.sv
// Memory-side responder: word-addressed RAM with 1-cycle registered reads,
// byte-enable writes, and a byte-stream loader that fills RAM after reset
// while holding the core in reset, then hands over to the core (RUN).
//   clk, rst : clock, synchronous active-high reset
//   clk_en   : enables run-mode reads/writes (loader ignores it)
//   bus      : ram_responder_if.slave (fetch/read/write/loader/status)
module ram_responder #(
    parameter int unsigned ADDR_WIDTH = 31,
    parameter int unsigned DATA_WIDTH = 31,
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    ram_responder_if.slave  bus
);
    localparam int unsigned DW    = DATA_WIDTH + 1;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic                 core_rst_q, core_rst_d;
    logic                 load_ready_q, load_ready_d;
    logic [1:0]           lane_q;
    logic [DW-1:0]        asm_q, asm_word;
    logic [CW-1:0]        load_words_q;
    logic [DW-1:0]        fetch_q, read_q;
    logic                 fault_q, fault_d;
    logic [DW-1:0]        mem [DEPTH];

    logic                  load_fire, load_full, load_wr, run_en;
    logic                  fetch_ok, rd_ok, wr_ok;
    logic [DEPTH_LOG2-1:0] fetch_idx, rd_idx, wr_idx;
    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [DW-1:0]         ram_wdata;

    // Handshake and address decode
    always_comb begin
        load_fire = (state_q == ST_LOAD) && bus.load_valid && load_ready_q;
        load_full = (load_words_q == CW'(DEPTH));
        // Higher lanes of asm_q are always zero, which zero-pads a short last word.
        asm_word  = asm_q | (DW'(bus.load_byte) << {lane_q, 3'b000});
        load_wr   = load_fire && ((lane_q == 2'd3) || bus.load_last) && !load_full;
        run_en    = (state_q == ST_RUN) && clk_en;
        fetch_ok  = (bus.read_fetch_addr[ADDR_WIDTH:DEPTH_LOG2] == '0);
        rd_ok     = (bus.read_addr[ADDR_WIDTH:DEPTH_LOG2] == '0);
        wr_ok     = (bus.write_addr[ADDR_WIDTH:DEPTH_LOG2] == '0);
        fetch_idx = bus.read_fetch_addr[DEPTH_LOG2-1:0];
        rd_idx    = bus.read_addr[DEPTH_LOG2-1:0];
        wr_idx    = bus.write_addr[DEPTH_LOG2-1:0];
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            core_rst_q   <= 1'b1;
            load_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_rst_q   <= core_rst_d;
            load_ready_q <= load_ready_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_LOAD) && load_fire && bus.load_last) begin
            state_d = ST_RUN;
        end
    end

    // FSM: outputs, computed from next state so they change with the state
    always_comb begin
        core_rst_d   = 1'b0;
        load_ready_d = 1'b0;
        if (state_d == ST_LOAD) begin
            core_rst_d   = 1'b1;
            load_ready_d = 1'b1;
        end
    end

    // Loader byte assembly and word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q       <= 2'd0;
            asm_q        <= '0;
            load_words_q <= '0;
        end else if (load_fire) begin
            if ((lane_q == 2'd3) || bus.load_last) begin
                lane_q <= 2'd0;
                asm_q  <= '0;
            end else begin
                lane_q <= lane_q + 2'd1;
                asm_q  <= asm_word;
            end
            if (load_wr) begin
                load_words_q <= load_words_q + CW'(1);
            end
        end
    end

    // Single RAM write port shared by loader (LOAD) and core (RUN)
    always_comb begin
        ram_we    = 1'b0;
        ram_be    = 4'h0;
        ram_idx   = wr_idx;
        ram_wdata = bus.write_data;
        if (load_wr) begin
            ram_we    = 1'b1;
            ram_be    = 4'hF;
            ram_idx   = load_words_q[DEPTH_LOG2-1:0];
            ram_wdata = asm_word;
        end else if (run_en && bus.write_enable && wr_ok) begin
            ram_we = 1'b1;
            ram_be = bus.byte_enable;
        end
    end

    // RAM array, contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && ram_be[i]) begin
                mem[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

    // Sticky fault on out-of-range access or loader overflow
    always_comb begin
        fault_d = fault_q;
        if (load_fire && load_full) fault_d = 1'b1;
        if (run_en) begin
            if (!fetch_ok)                     fault_d = 1'b1;
            if (bus.read_req && !rd_ok)        fault_d = 1'b1;
            if (bus.write_enable && !wr_ok)    fault_d = 1'b1;
        end
    end

    // Registered read ports; nonblocking reads give read-first behaviour
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q <= '0;
            read_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
            if (run_en) begin
                fetch_q <= fetch_ok ? mem[fetch_idx] : '0;
                if (bus.read_req) begin
                    read_q <= rd_ok ? mem[rd_idx] : '0;
                end
            end
        end
    end

    assign bus.read_fetch_data = fetch_q;
    assign bus.read_data       = read_q;
    assign bus.load_ready      = load_ready_q;
    assign bus.core_rst        = core_rst_q;
    assign bus.load_words      = load_words_q;
    assign bus.fault           = fault_q;
endmodule
